// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RF+ALU datapath: walks each instruction through
// IDLE/IF/ID/EXE/MEM/WB and Moore-decodes every datapath, fetch and memory control.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] Ins,
  input  logic        MemReady,
  output logic        WBRF,
  output logic        WBresource,
  output logic        RBresource,
  output logic        OprandB,
  output logic        LI,
  output logic        Buff_IDEXE,
  output logic        PSW_C,
  output logic        ALUop,
  output logic        Flag,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCsrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        PSWWrite,
  output logic        OutRWrite,
  output logic        MemErr,
  output logic [2:0]  State
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EXE  = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;

  localparam logic [4:0] OP_ALU    = 5'b00000;
  localparam logic [4:0] OP_LHI    = 5'b00001;
  localparam logic [4:0] OP_LLI    = 5'b00010;
  localparam logic [4:0] OP_LDR_RI = 5'b00011;
  localparam logic [4:0] OP_LDR_RR = 5'b00100;
  localparam logic [4:0] OP_STR_RI = 5'b00101;
  localparam logic [4:0] OP_STR_RR = 5'b00110;
  localparam logic [4:0] OP_CMP    = 5'b00111;
  localparam logic [4:0] OP_ADDI   = 5'b01000;
  localparam logic [4:0] OP_SUBI   = 5'b01001;
  localparam logic [4:0] OP_MOV    = 5'b01010;
  localparam logic [4:0] OP_JAL_RL = 5'b01011;
  localparam logic [4:0] OP_JAL_RR = 5'b01100;
  localparam logic [4:0] OP_JR     = 5'b01101;
  localparam logic [4:0] OP_OUTR   = 5'b01110;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  logic [4:0] w_op;
  logic [1:0] w_fn;
  logic       w_is_ldr;
  logic       w_is_str;
  logic       w_timeout;
  logic       w_unused;

  assign w_op      = Ins[15:11];
  assign w_fn      = Ins[1:0];
  assign w_is_ldr  = (w_op == OP_LDR_RI) || (w_op == OP_LDR_RR);
  assign w_is_str  = (w_op == OP_STR_RI) || (w_op == OP_STR_RR);
  assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 32'd1));
  assign w_unused  = ^Ins[10:2];

  assign State  = r_state;
  assign MemErr = r_mem_err;

  // State register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // MEM wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else if (r_state == S_MEM) begin
      if (MemReady) begin
        r_cnt <= '0;
      end else if (w_timeout) begin
        r_cnt     <= '0;
        r_mem_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = S_IF;
      S_IF:   w_next = S_ID;
      S_ID: begin
        case (w_op)
          OP_LHI, OP_LLI, OP_MOV:                         w_next = S_WB;
          OP_ALU, OP_LDR_RI, OP_LDR_RR, OP_STR_RI,
          OP_STR_RR, OP_CMP, OP_ADDI, OP_SUBI, OP_OUTR:   w_next = S_EXE;
          default:                                        w_next = S_IF;
        endcase
      end
      S_EXE: begin
        if (w_is_ldr || w_is_str)                     w_next = S_MEM;
        else if (w_op == OP_CMP || w_op == OP_OUTR)   w_next = S_IF;
        else                                          w_next = S_WB;
      end
      S_MEM: begin
        if (MemReady)       w_next = w_is_ldr ? S_WB : S_IF;
        else if (w_timeout) w_next = S_IF;
        else                w_next = S_MEM;
      end
      S_WB:    w_next = S_IF;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore output decode from state and instruction fields
  always_comb begin
    WBRF       = 1'b0;
    WBresource = 1'b0;
    RBresource = 1'b0;
    OprandB    = 1'b0;
    LI         = 1'b0;
    Buff_IDEXE = 1'b0;
    PSW_C      = 1'b0;
    ALUop      = 1'b0;
    Flag       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCsrc      = 2'b00;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    PSWWrite   = 1'b0;
    OutRWrite  = 1'b0;
    case (r_state)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_ID: begin
        case (w_op)
          OP_LHI: begin
            RBresource = 1'b1;
            Buff_IDEXE = 1'b1;
          end
          OP_LLI: begin
            LI         = 1'b1;
            Buff_IDEXE = 1'b1;
          end
          OP_LDR_RI, OP_STR_RI, OP_ADDI, OP_SUBI: begin
            OprandB    = 1'b1;
            Buff_IDEXE = 1'b1;
          end
          OP_ALU, OP_LDR_RR, OP_STR_RR, OP_CMP, OP_MOV, OP_OUTR: begin
            Buff_IDEXE = 1'b1;
          end
          OP_JAL_RL, OP_JAL_RR, OP_JR: begin
            WBRF       = 1'b1;
            WBresource = 1'b1;
            RBresource = (w_op == OP_JR);
            PCWrite    = 1'b1;
            PCsrc      = (w_op == OP_JAL_RL) ? 2'b01 :
                         (w_op == OP_JAL_RR) ? 2'b10 : 2'b11;
          end
          default: ;
        endcase
      end
      S_EXE: begin
        case (w_op)
          OP_ALU: begin
            case (w_fn)
              2'b00:   {PSW_C, ALUop, Flag} = 3'b100;
              2'b01:   {PSW_C, ALUop, Flag} = 3'b101;
              2'b10:   {PSW_C, ALUop, Flag} = 3'b010;
              default: {PSW_C, ALUop, Flag} = 3'b011;
            endcase
            PSWWrite = 1'b1;
          end
          OP_ADDI: begin
            {PSW_C, ALUop, Flag} = 3'b100;
            PSWWrite             = 1'b1;
          end
          OP_SUBI, OP_CMP: begin
            {PSW_C, ALUop, Flag} = 3'b010;
            PSWWrite             = 1'b1;
          end
          OP_LDR_RI, OP_LDR_RR: {PSW_C, ALUop, Flag} = 3'b100;
          OP_STR_RI, OP_STR_RR: begin
            {PSW_C, ALUop, Flag} = 3'b100;
            RBresource           = 1'b1;
          end
          OP_OUTR: OutRWrite = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        if (w_is_ldr) begin
          MemRead = 1'b1;
        end else if (w_is_str) begin
          MemWrite             = 1'b1;
          RBresource           = 1'b1;
          {PSW_C, ALUop, Flag} = 3'b100;
        end
      end
      S_WB: begin
        WBRF       = 1'b1;
        WBresource = !w_is_ldr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction's expected per-cycle control trace is
// generated from its opcode class and memory latency, then compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] Ins;
  logic        MemReady;
  logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE;
  logic        PSW_C, ALUop, Flag, IRWrite, PCWrite;
  logic [1:0]  PCsrc;
  logic        MemRead, MemWrite, PSWWrite, OutRWrite, MemErr;
  logic [2:0]  State;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .MemReady(MemReady),
    .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource),
    .OprandB(OprandB), .LI(LI), .Buff_IDEXE(Buff_IDEXE),
    .PSW_C(PSW_C), .ALUop(ALUop), .Flag(Flag),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .PSWWrite(PSWWrite),
    .OutRWrite(OutRWrite), .MemErr(MemErr), .State(State)
  );

  // {id6, alu3, IRWrite, PCWrite, PCsrc, MemRead, MemWrite, PSWWrite, OutRWrite}
  wire [16:0] w_ctl = {WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE,
                       PSW_C, ALUop, Flag, IRWrite, PCWrite, PCsrc,
                       MemRead, MemWrite, PSWWrite, OutRWrite};

  typedef struct packed {
    logic [2:0]  st;
    logic [16:0] ctl;
    logic        err;
  } step_t;

  step_t trace[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] cw(input logic [5:0] id6, input logic [2:0] alu,
                                     input logic [1:0] fetch, input logic [1:0] pcsrc,
                                     input logic [3:0] misc);
    return {id6, alu, fetch, pcsrc, misc};
  endfunction

  function automatic void push(input logic [2:0] st, input logic [16:0] ctl);
    step_t s;
    s.st  = st;
    s.ctl = ctl;
    s.err = exp_err;
    trace.push_back(s);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from IF until just before the next IF
  task automatic build(input logic [15:0] ins, input int lat);
    logic [4:0] op;
    logic [1:0] fn;
    logic       ldr, str, imm, alu_rr, addi, subi, cmp, outr, psw, to_wb;
    logic [2:0] alu;
    logic [5:0] id6;
    int         n_mem;
    op     = ins[15:11];
    fn     = ins[1:0];
    ldr    = (op == 5'd3) || (op == 5'd4);
    str    = (op == 5'd5) || (op == 5'd6);
    addi   = (op == 5'd8);
    subi   = (op == 5'd9);
    imm    = (op == 5'd3) || (op == 5'd5) || addi || subi;
    alu_rr = (op == 5'd0);
    cmp    = (op == 5'd7);
    outr   = (op == 5'd14);
    push(3'd1, cw(6'b0, 3'b0, 2'b11, 2'b00, 4'b0));
    if (op > 5'd14) begin
      push(3'd2, '0);
      return;
    end
    if (op >= 5'd11 && op <= 5'd13) begin
      push(3'd2, cw((op == 5'd13) ? 6'b111000 : 6'b110000, 3'b0, 2'b01,
                    (op == 5'd11) ? 2'b01 : (op == 5'd12) ? 2'b10 : 2'b11, 4'b0));
      return;
    end
    id6 = (op == 5'd1) ? 6'b001001 : (op == 5'd2) ? 6'b000011 :
          imm ? 6'b000101 : 6'b000001;
    push(3'd2, cw(id6, 3'b0, 2'b00, 2'b00, 4'b0));
    to_wb = (op == 5'd1) || (op == 5'd2) || (op == 5'd10);
    if (!to_wb) begin
      if (ldr || str || addi || (alu_rr && fn == 2'd0)) alu = 3'b100;
      else if (alu_rr && fn == 2'd1)                    alu = 3'b101;
      else if (subi || cmp || (alu_rr && fn == 2'd2))   alu = 3'b010;
      else if (alu_rr)                                  alu = 3'b011;
      else                                              alu = 3'b000;
      psw = alu_rr || cmp || addi || subi;
      push(3'd3, cw(str ? 6'b001000 : 6'b0, alu, 2'b00, 2'b00, {2'b00, psw, outr}));
      if (cmp || outr) return;
      if (ldr || str) begin
        n_mem = (lat < int'(TO)) ? lat + 1 : int'(TO);
        for (int k = 0; k < n_mem; k++)
          push(3'd4, ldr ? cw(6'b0, 3'b0, 2'b00, 2'b00, 4'b1000)
                         : cw(6'b001000, 3'b100, 2'b00, 2'b00, 4'b0100));
        if (lat >= int'(TO)) begin
          exp_err = 1'b1;
          return;
        end
        if (str) return;
      end
    end
    push(3'd5, cw(ldr ? 6'b100000 : 6'b110000, 3'b0, 2'b00, 2'b00, 4'b0));
  endtask

  // Execute one instruction starting at an IF negedge; stop_at >= 0 leaves it mid-flight
  task automatic run(input logic [15:0] ins, input int lat, input int stop_at);
    int mem_idx;
    mem_idx = 0;
    trace.delete();
    build(ins, lat);
    foreach (trace[i]) begin
      if (i == stop_at) return;
      check($sformatf("state ins=%h step=%0d", ins, i), 32'(State), 32'(trace[i].st));
      check($sformatf("ctl ins=%h step=%0d", ins, i), 32'(w_ctl), 32'(trace[i].ctl));
      check($sformatf("memerr ins=%h step=%0d", ins, i), 32'(MemErr), 32'(trace[i].err));
      if (trace[i].st == 3'd1) Ins = ins;
      if (trace[i].st == 3'd4) begin
        MemReady = (mem_idx == lat);
        mem_idx++;
      end else begin
        MemReady = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [15:0] ins;
    Reset    = 1'b0;
    Ins      = 16'h0000;
    MemReady = 1'b0;
    exp_err  = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset state", 32'(State), 32'd0);
      check("reset ctl", 32'(w_ctl), 32'd0);
      check("reset memerr", 32'(MemErr), 32'd0);
    end
    Reset = 1'b1;
    check("idle state", 32'(State), 32'd0);
    check("idle ctl", 32'(w_ctl), 32'd0);
    @(negedge clk);

    run(16'h0005, 0, -1);      // ADC
    run(16'h1925, 3, -1);      // LDR_RI with 3 wait cycles
    run(16'h3000, 1000, -1);   // STR_RR, memory never ready
    run(16'h0000, 0, -1);      // ADD after timeout: MemErr stays set
    run(16'h6B00, 0, -1);      // JR
    run(16'hF800, 0, -1);      // undefined opcode
    run(16'h2800, int'(TO) - 1, -1);  // ready on the timeout cycle
    run(16'h0807, 0, -1);      // LHI
    run(16'h1007, 0, -1);      // LLI
    run(16'h7000, 0, -1);      // OutR
    run(16'h3800, 0, -1);      // CMP

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(15, 31));
      else                           op = 5'($urandom_range(0, 14));
      ins = {op, 11'($urandom)};
      run(ins, int'($urandom_range(0, 17)), -1);
    end

    // Abort a store mid-MEM with an asynchronous reset
    run(16'h3000, 1000, 3);
    check("abort pre memwrite", 32'(MemWrite), 32'd1);
    check("abort pre state", 32'(State), 32'd4);
    check("abort pre memerr", 32'(MemErr), 32'(exp_err));
    #2 Reset = 1'b0;
    #1;
    check("abort memwrite", 32'(MemWrite), 32'd0);
    check("abort state", 32'(State), 32'd0);
    check("abort memerr", 32'(MemErr), 32'd0);
    exp_err = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    run(16'h0005, 0, -1);
    run(16'h2000, 2, -1);      // LDR_RR

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
